// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - Shared states, encodings and condition evaluation for the multicycle control unit
package mc_ctrl_pkg;

    localparam int MC_ALUCTL_W = 3;
    localparam int MC_NFLAGS   = 4;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWRITE,
        S_MEMWB,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH
    } state_e;

    localparam logic [MC_ALUCTL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [MC_ALUCTL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [MC_ALUCTL_W-1:0] ALU_AND = 3'b010;
    localparam logic [MC_ALUCTL_W-1:0] ALU_ORR = 3'b011;
    localparam logic [MC_ALUCTL_W-1:0] ALU_EOR = 3'b100;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    typedef struct packed {
        logic [MC_ALUCTL_W-1:0] alu_ctl;
        logic                   no_write;
        logic                   upd_cv;
        logic                   bad_cmd;
    } dp_dec_t;

    // Flags are ordered {N,Z,C,V}; 1111 is the never-execute code.
    function automatic logic condex(input logic [3:0] cond, input logic [MC_NFLAGS-1:0] flags);
        logic n, z, c, v, res;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - Instruction fields into the controller, datapath controls and flags out
interface mc_control_unit_if;
    import mc_ctrl_pkg::*;

    logic [3:0]             Cond;
    logic [1:0]             op;
    logic [5:0]             funct;
    logic [3:0]             Rd;
    logic [MC_NFLAGS-1:0]   ALUFlags;

    logic                   PCWrite;
    logic                   AdrSrc;
    logic                   MemWrite;
    logic                   IRWrite;
    logic [1:0]             ResultSrc;
    logic                   ALUSrcA;
    logic [1:0]             ALUSrcB;
    logic [MC_ALUCTL_W-1:0] ALUControl;
    logic [1:0]             ImmSrc;
    logic [1:0]             RegSrc;
    logic                   RegWrite;
    logic                   LinkSel;
    logic                   Illegal;
    logic [MC_NFLAGS-1:0]   Flags;

    modport master (
        input  Cond, op, funct, Rd, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegSrc, RegWrite, LinkSel, Illegal, Flags
    );

    modport slave (
        output Cond, op, funct, Rd, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegSrc, RegWrite, LinkSel, Illegal, Flags
    );

endinterface

// File: rtl/mc_cond_unit.sv
// rtl/mc_cond_unit.sv - NZCV flag register, per-instruction condition latch and write gating
module mc_cond_unit
    import mc_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           cond,
    input  logic [MC_NFLAGS-1:0] alu_flags,
    input  logic                 cond_latch,
    input  logic                 nz_we,
    input  logic                 cv_we,
    input  logic [3:0]           wr_req,
    output logic [3:0]           wr_gated,
    output logic [MC_NFLAGS-1:0] flags
);

    logic [MC_NFLAGS-1:0] flags_q, flags_d;
    logic                 cond_q, cond_d;

    always_comb begin
        flags_d = flags_q;
        cond_d  = cond_q;
        if (cond_latch) begin
            cond_d = condex(cond, flags_q);
        end
        // Gated by the latched condition so an update here never changes the later write-back.
        if (nz_we && cond_q) begin
            flags_d[3:2] = alu_flags[3:2];
        end
        if (cv_we && cond_q) begin
            flags_d[1:0] = alu_flags[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            cond_q  <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cond_q  <= cond_d;
        end
    end

    assign wr_gated = wr_req & {4{cond_q}};
    assign flags    = flags_q;

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - Multicycle ARM control FSM and instruction decoder
// MC_CTRL_BL_EN: branch-with-link writes R14 in the BRANCH cycle.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTL_W = 3,
    parameter int NFLAGS   = 4
) (
    input  logic               CLK,
    input  logic               reset,
    mc_control_unit_if.master  bus
);

    if (NFLAGS != MC_NFLAGS || ALUCTL_W != MC_ALUCTL_W) begin : g_bad_width
        $error("mc_control_unit: NFLAGS must be 4 and ALUCTL_W must be 3");
    end

    state_e     state_q, state_d;
    dp_dec_t    dp_dec;
    logic       ir_write, pc_uncond, illegal_raw;
    logic       cond_latch, nz_we, cv_we;
    logic       pc_req, reg_req, mem_req, link_req;
    logic [3:0] wr_gated;

    always_comb begin
        dp_dec.alu_ctl  = ALU_ADD;
        dp_dec.no_write = 1'b0;
        dp_dec.upd_cv   = 1'b1;
        dp_dec.bad_cmd  = 1'b0;
        case (bus.funct[4:1])
            CMD_ADD: dp_dec.alu_ctl = ALU_ADD;
            CMD_SUB: dp_dec.alu_ctl = ALU_SUB;
            CMD_AND: begin dp_dec.alu_ctl = ALU_AND; dp_dec.upd_cv = 1'b0; end
            CMD_ORR: begin dp_dec.alu_ctl = ALU_ORR; dp_dec.upd_cv = 1'b0; end
            CMD_EOR: begin dp_dec.alu_ctl = ALU_EOR; dp_dec.upd_cv = 1'b0; end
            CMD_CMP: begin dp_dec.alu_ctl = ALU_SUB; dp_dec.no_write = 1'b1; end
            CMD_TST: begin
                dp_dec.alu_ctl  = ALU_AND;
                dp_dec.no_write = 1'b1;
                dp_dec.upd_cv   = 1'b0;
            end
            default: dp_dec.bad_cmd = 1'b1;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        bus.AdrSrc     = 1'b0;
        bus.ResultSrc  = RES_ALUOUT;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = SRCB_RD2;
        bus.ALUControl = ALU_ADD;
        ir_write       = 1'b0;
        pc_uncond      = 1'b0;
        illegal_raw    = 1'b0;
        cond_latch     = 1'b0;
        nz_we          = 1'b0;
        cv_we          = 1'b0;
        pc_req         = 1'b0;
        reg_req        = 1'b0;
        mem_req        = 1'b0;
        link_req       = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write      = 1'b1;
                pc_uncond     = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
                cond_latch    = 1'b1;
                case (bus.op)
                    OP_MEM: state_d = S_MEMADR;
                    OP_DP: begin
                        state_d     = bus.funct[5] ? S_EXECUTEI : S_EXECUTER;
                        illegal_raw = dp_dec.bad_cmd;
                    end
                    OP_BR:  state_d = S_BRANCH;
                    OP_ILL: begin
                        illegal_raw = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcB    = SRCB_EXTIMM;
                bus.ALUControl = bus.funct[3] ? ALU_ADD : ALU_SUB;
                state_d        = bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.AdrSrc = 1'b1;
                state_d    = S_MEMWB;
            end
            S_MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                mem_req    = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWB, S_ALUWB: begin
                bus.ResultSrc = (state_q == S_MEMWB) ? RES_DATA : RES_ALUOUT;
                // A write to R15 is a jump: it goes to the PC instead of the register file.
                pc_req        = (bus.Rd == 4'd15);
                reg_req       = (bus.Rd != 4'd15);
                state_d       = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
                bus.ALUSrcB    = (state_q == S_EXECUTEI) ? SRCB_EXTIMM : SRCB_RD2;
                bus.ALUControl = dp_dec.alu_ctl;
                nz_we          = bus.funct[0] | dp_dec.no_write;
                cv_we          = (bus.funct[0] | dp_dec.no_write) & dp_dec.upd_cv;
                state_d        = dp_dec.no_write ? S_FETCH : S_ALUWB;
            end
            S_BRANCH: begin
                bus.ALUSrcB    = SRCB_EXTIMM;
                bus.ALUControl = ALU_ADD;
                bus.ResultSrc  = RES_ALURESULT;
                pc_req         = 1'b1;
`ifdef MC_CTRL_BL_EN
                link_req       = bus.funct[4];
`endif
                state_d        = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    mc_cond_unit u_cond (
        .clk        (CLK),
        .rst_n      (reset),
        .cond       (bus.Cond),
        .alu_flags  (bus.ALUFlags),
        .cond_latch (cond_latch),
        .nz_we      (nz_we),
        .cv_we      (cv_we),
        .wr_req     ({link_req, mem_req, reg_req, pc_req}),
        .wr_gated   (wr_gated),
        .flags      (bus.Flags)
    );

    assign bus.PCWrite  = reset & (pc_uncond | wr_gated[0]);
    assign bus.RegWrite = reset & (wr_gated[1] | wr_gated[3]);
    assign bus.MemWrite = reset & wr_gated[2];
    assign bus.IRWrite  = reset & ir_write;
    assign bus.Illegal  = reset & illegal_raw;
    assign bus.ImmSrc   = bus.op;
    assign bus.RegSrc   = {bus.op == OP_MEM, bus.op == OP_BR};
`ifdef MC_CTRL_BL_EN
    assign bus.LinkSel  = reset & wr_gated[3];
`else
    assign bus.LinkSel  = 1'b0;
`endif

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle ARM control unit; the successor to the single-cycle controller.
- Contains a per-instruction FSM, a registered NZCV flag file, condition evaluation latched per instruction, and a wider ALU command set (ADD/SUB/AND/ORR/EOR/CMP/TST).
- Drives the shared multicycle datapath: one memory port, IR, PC, register file, ALU and result mux.

Parameters:
- ALUCTL_W, 3: ALUControl width. Encoding: ADD=000, SUB=001, AND=010, ORR=011, EOR=100.
- NFLAGS, 4: flag file width, ordered {N,Z,C,V}. Fixed to 4; any other value is an elaboration error.

Ports:
- CLK  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- Cond  in  4  Instr[31:28].
- op  in  2  Instr[27:26].
- funct  in  6  Instr[25:20].
- Rd  in  4  Instr[15:12].
- ALUFlags  in  NFLAGS  N,Z,C,V from the ALU in the current cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUResult.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  instruction register enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  1  ALU A select: 0 = RD1, 1 = PC.
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ExtImm, 10 = constant 4.
- ALUControl  out  ALUCTL_W  ALU operation.
- ImmSrc  out  2  equals op.
- RegSrc  out  2  {op==01, op==10}.
- RegWrite  out  1  register file write enable.
- LinkSel  out  1  write R14 with PC (see Optional Feature).
- Illegal  out  1  one-cycle pulse in DECODE when op==11.
- Flags  out  NFLAGS  current flag register.

Behaviour:
- While reset is low:
  - state = FETCH; Flags = 0; cond_q = 0.
  - PCWrite, IRWrite, MemWrite, RegWrite, Illegal are forced to 0.
  - All other outputs take their FETCH values.
- FSM states, one instruction at a time, no overlap:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10. cond_q <= CondEx(Cond, Flags).
    - op=01 -> MEMADR.
    - op=00 with funct[5]=0 -> EXECUTER.
    - op=00 with funct[5]=1 -> EXECUTEI.
    - op=10 -> BRANCH.
    - op=11 -> Illegal=1, next FETCH.
  - MEMADR: ALUSrcB=01, ALUControl = ADD if funct[3] (U) else SUB. Next: funct[0] ? MEMREAD : MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
  - MEMWRITE: AdrSrc=1, MemWrite=cond_q. Next: FETCH.
  - MEMWB: ResultSrc=01, write-back (see PC-destination rule below). Next: FETCH.
  - EXECUTER / EXECUTEI: ALUSrcB = 00 / 01; ALUControl from funct[4:1] cmd. Next: FETCH if NoWrite, else ALUWB.
  - ALUWB: ResultSrc=00, write-back. Next: FETCH.
  - BRANCH: ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=cond_q. Next: FETCH.
- ALU command decode (cmd = funct[4:1]):
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR.
  - 1010 CMP -> SUB, NoWrite=1.
  - 1000 TST -> AND, NoWrite=1.
  - Any other cmd -> ADD, Illegal pulse in DECODE.
  - CMP/TST with S=0 behave as CMP/TST with S=1.
- Flag update, at the clock edge leaving EXECUTER/EXECUTEI, only when S (funct[0]) is set and cond_q=1:
  - N and Z always update.
  - C and V update only for ADD/SUB/CMP.
  - Flags are never written in any other state.
- Condition evaluation:
  - EQ..LE per the ARM table; AL(1110)=1; 1111=0.
  - Evaluated only in DECODE and held in cond_q for the whole instruction, so a flag update in the execute state does not alter the gating of ALUWB.
- Write-back in MEMWB/ALUWB:
  - Rd!=15: RegWrite = cond_q.
  - Rd==15: RegWrite=0 and PCWrite = cond_q; this is the PC-destination rule.
- Latency in cycles: data-processing 4 (3 for CMP/TST), LDR 5, STR 4, B 3.
- An asynchronous reset assertion mid-instruction abandons that instruction. No partial writes occur after the reset edge.

Optional Feature:
- Macro MC_CTRL_BL_EN.
- Defined: in BRANCH with funct[4] (L) set and cond_q=1, assert RegWrite=1 and LinkSel=1 in the same cycle as PCWrite. R14 receives PC+4.
- Undefined: LinkSel is tied to 0 and BL executes as B.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum;
  - ALUControl localparams;
  - cmd codes and condition-code localparams;
  - ResultSrc/ALUSrcB encodings;
  - the condex() function.
- One sub-module, mc_cond_unit: flag register, cond_q latch and write gating.
- The FSM and decoder stay in mc_control_unit.

Test Plan:
- reset low for 3 cycles, then release -> Flags=0000, first cycle in FETCH with IRWrite=1, PCWrite=1. No write enable asserted during reset.
- ADDS R1,R2,R3 (op=00, funct=001001) with ALUFlags=0100 in EXECUTER -> states FETCH,DECODE,EXECUTER,ALUWB; Flags=0100 afterwards; RegWrite=1 only in ALUWB.
- CMP (funct=010101) with ALUFlags=0110, followed by BNE (Cond=0001, op=10) -> CMP takes 3 cycles, Flags=0110; BRANCH has PCWrite=0. A following BEQ has PCWrite=1.
- LDR (op=01, funct=011001) with Rd=15 -> MEMADR,MEMREAD,MEMWB sequence with AdrSrc=1 in MEMREAD; in MEMWB PCWrite=1, RegWrite=0.
- Cond=1111 STR -> MemWrite stays 0; instruction still returns to FETCH after 4 cycles.
- op=11 in DECODE -> Illegal pulses for one cycle, next state FETCH. With MC_CTRL_BL_EN, BL (funct[4]=1, Cond=1110) -> LinkSel=1, RegWrite=1, PCWrite=1 in BRANCH.
